// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: same-cycle hits, per-word refill over a
// request/acknowledge bus, and index-invalidate cache operations.
// Optional feature macro: ICACHE_STATS_EN adds hit/miss counter outputs.
module icache_direct #(
    parameter int unsigned OFFSET_BITS = 3,
    parameter int unsigned INDEX_BITS  = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic        i_stb,
    output logic [31:0] o_inst_out,
    output logic        o_stall,
    input  logic        i_cache_op,
    input  logic [31:0] i_cache_op_addr,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_stb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data_in
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    localparam int unsigned WORDS    = 1 << OFFSET_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned IDX_LSB  = OFFSET_BITS + 2;
    localparam int unsigned TAG_LSB  = OFFSET_BITS + INDEX_BITS + 2;
    localparam int unsigned TAG_BITS = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_INVAL
    } state_t;

    // Storage: data and tags are plain arrays (no reset), valid bits in flops.
    logic [31:0]            r_data [LINES*WORDS];
    logic [TAG_BITS-1:0]    r_tag  [LINES];
    logic [LINES-1:0]       r_valid;

    state_t                 r_state;
    logic [31:0]            r_fill_addr;
    logic [OFFSET_BITS-1:0] r_word_cnt;
    logic                   r_pending_op;
    logic [INDEX_BITS-1:0]  r_op_index;
    logic                   r_mem_stb;
    logic [31:0]            r_mem_addr;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [OFFSET_BITS-1:0] w_offset;
    logic [INDEX_BITS-1:0]  w_op_index;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic [31:0]            w_line_base;
    logic [OFFSET_BITS-1:0] w_next_cnt;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_fill_we;
    logic                   w_last_word;
    logic                   w_unused;

    assign w_tag        = i_addr[31:TAG_LSB];
    assign w_index      = i_addr[TAG_LSB-1:IDX_LSB];
    assign w_offset     = i_addr[IDX_LSB-1:2];
    assign w_op_index   = i_cache_op_addr[TAG_LSB-1:IDX_LSB];
    assign w_fill_index = r_fill_addr[TAG_LSB-1:IDX_LSB];
    assign w_fill_tag   = r_fill_addr[31:TAG_LSB];
    assign w_line_base  = {i_addr[31:IDX_LSB], IDX_LSB'(0)};
    assign w_next_cnt   = r_word_cnt + OFFSET_BITS'(1);
    assign w_last_word  = (r_word_cnt == OFFSET_BITS'(WORDS - 1));

    // Byte-lane and out-of-field address bits carry no meaning here.
    assign w_unused = ^{i_addr[1:0], i_cache_op_addr[31:TAG_LSB], i_cache_op_addr[IDX_LSB-1:0]};

    // Lookup is fully combinational so a hit is served in the fetch cycle.
    assign w_hit      = i_stb & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_miss     = (r_state == S_IDLE) & i_stb & ~w_hit;
    assign o_inst_out = r_data[{w_index, w_offset}];
    assign o_stall    = (r_state != S_IDLE) | (i_stb & ~w_hit) |
                        ((r_state == S_IDLE) & r_pending_op);
    assign o_mem_stb  = r_mem_stb;
    assign o_mem_addr = r_mem_addr;

    assign w_fill_we = ~i_rst & (r_state == S_REFILL) & i_mem_ack & r_mem_stb;

    // Refill writes into the data array; the tag lands with the last word.
    always_ff @(posedge i_clk) begin
        if (w_fill_we) begin
            r_data[{w_fill_index, r_word_cnt}] <= i_mem_data_in;
            if (w_last_word) begin
                r_tag[w_fill_index] <= w_fill_tag;
            end
        end
    end

    // Control FSM: miss detection, line refill, deferred index invalidate.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_fill_addr  <= '0;
            r_word_cnt   <= '0;
            r_pending_op <= 1'b0;
            r_op_index   <= '0;
            r_mem_stb    <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_fill_addr <= w_line_base;
                        r_word_cnt  <= '0;
                        r_mem_stb   <= 1'b1;
                        r_mem_addr  <= w_line_base;
                        r_state     <= S_REFILL;
                        // A same-cycle op waits until the refill is done.
                        if (i_cache_op) begin
                            r_pending_op <= 1'b1;
                            r_op_index   <= w_op_index;
                        end
                    end else if (i_cache_op || r_pending_op) begin
                        if (i_cache_op) begin
                            r_op_index <= w_op_index;
                        end
                        r_state <= S_INVAL;
                    end
                end
                S_REFILL: begin
                    if (i_cache_op) begin
                        r_pending_op <= 1'b1;
                        r_op_index   <= w_op_index;
                    end
                    if (i_mem_ack && r_mem_stb) begin
                        r_word_cnt <= w_next_cnt;
                        r_mem_addr <= r_fill_addr + 32'({w_next_cnt, 2'b00});
                        if (w_last_word) begin
                            r_valid[w_fill_index] <= 1'b1;
                            r_mem_stb             <= 1'b0;
                            r_state               <= S_IDLE;
                        end
                    end
                end
                S_INVAL: begin
                    r_valid[r_op_index] <= 1'b0;
                    // An op arriving during the invalidate cycle is kept for later.
                    r_pending_op        <= i_cache_op;
                    if (i_cache_op) begin
                        r_op_index <= w_op_index;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit/miss statistics, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule
